multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_pkg.sv | 73 +++++++
 rtl/alu_control.sv | 29 ++
 rtl/wait_counter.sv | 22 ++
 rtl/multicycle_control.sv | 154 +++++++++++++++
 tb/tb_multicycle_control.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared multicycle MIPS definitions: FSM states, opcodes,
// ALU operation codes and the control-word bundle.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALUC_AND = 4'b0000;
  localparam logic [3:0] ALUC_OR  = 4'b0001;
  localparam logic [3:0] ALUC_ADD = 4'b0010;
  localparam logic [3:0] ALUC_SUB = 4'b0110;
  localparam logic [3:0] ALUC_SLT = 4'b0111;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW ||
           op == OP_BEQ || op == OP_J || op == OP_ADDI;
  endfunction

endpackage

// File: rtl/alu_control.sv
// ALU operation select from the FSM ALUOp code and the
// R-type funct field.
module alu_control
  import mips_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] funct,
  output logic [3:0] ALUCnt
);

  always_comb begin
    ALUCnt = ALUC_ADD;
    case (ALUOp)
      ALUOP_SUB: ALUCnt = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  ALUCnt = ALUC_ADD;
          FN_SUB:  ALUCnt = ALUC_SUB;
          FN_AND:  ALUCnt = ALUC_AND;
          FN_OR:   ALUCnt = ALUC_OR;
          FN_SLT:  ALUCnt = ALUC_SLT;
          default: ALUCnt = ALUC_ADD;
        endcase
      end
      default: ALUCnt = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/wait_counter.sv
// Cycle counter for memory-access states; done marks the
// last cycle of the wait.
module wait_counter #(
  parameter logic [3:0] LAST = 4'd0
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] count,
  output logic       done
);

  always_ff @(posedge clk) begin
    if (clear)
      count <= 4'd0;
    else if (enable)
      count <= count + 4'd1;
  end

  assign done = (count == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM with parameterised
// memory-access latency.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  state_t     cur, nxt;
  ctl_t       ctl;
  logic       is_load;
  logic       wait_st, done, clear, enable;
  logic [3:0] count;

  assign wait_st = (cur == S_FETCH) || (cur == S_MEMRD) ||
                   (cur == S_MEMWR);
  assign enable  = wait_st && !done && !reset;
  assign clear   = reset || !wait_st || done;

  wait_counter #(.LAST(LAST)) u_wait (
    .clk    (clk),
    .clear  (clear),
    .enable (enable),
    .count  (count),
    .done   (done)
  );

  always_ff @(posedge clk) begin
    if (reset)
      cur <= S_FETCH;
    else
      cur <= nxt;
  end

  // lw/sw choice is captured in DECODE so later Op changes are ignored
  always_ff @(posedge clk) begin
    if (reset)
      is_load <= 1'b0;
    else if (cur == S_DECODE)
      is_load <= (Op == OP_LW);
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  if (done) nxt = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_RTYPE:     nxt = S_EXEC;
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI:      nxt = S_ADDIEX;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = is_load ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (done) nxt = S_MEMWB;
      S_MEMWR:  if (done) nxt = S_FETCH;
      S_EXEC:   nxt = S_RWB;
      S_ADDIEX: nxt = S_ADDIWB;
      default:  nxt = S_FETCH;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (cur)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_4;
        ctl.ir_write  = done;
        ctl.pc_write  = done;
      end
      S_DECODE: ctl.alu_src_b = SRCB_SHIFT;
      S_MEMADR, S_ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = ALUOP_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCSRC_OUT;
      end
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCSRC_JMP;
      end
      S_ADDIWB: ctl.reg_write = 1'b1;
      default:  ctl = '0;
    endcase
    if (reset)
      ctl = '0;
  end

  assign PCWrite     = ctl.pc_write;
  assign PCWriteCond = ctl.pc_write_cond;
  assign IorD        = ctl.iord;
  assign MemRead     = ctl.mem_read;
  assign MemWrite    = ctl.mem_write;
  assign IRWrite     = ctl.ir_write;
  assign MemtoReg    = ctl.mem_to_reg;
  assign RegDst      = ctl.reg_dst;
  assign RegWrite    = ctl.reg_write;
  assign ALUSrcA     = ctl.alu_src_a;
  assign ALUSrcB     = ctl.alu_src_b;
  assign ALUOp       = ctl.alu_op;
  assign PCSource    = ctl.pc_source;
  assign illegal_op  = !reset && (cur == S_DECODE) && !op_legal(Op);
  assign state       = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised instruction streams on MEM_LAT=1 and MEM_LAT=3
// controllers, checked against a per-instruction state-path model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset1, reset3;
  logic [5:0] op1, op3;
  logic [5:0] funct;

  logic pcw1, pcwc1, iord1, mr1, mw1, irw1, m2r1, rd1, rw1, sa1, ill1;
  logic pcw3, pcwc3, iord3, mr3, mw3, irw3, m2r3, rd3, rw3, sa3, ill3;
  logic [1:0] sb1, aop1, pcs1, sb3, aop3, pcs3;
  logic [3:0] st1, st3, alu_cnt;
  logic [16:0] ctl1, ctl3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset1), .Op(op1),
    .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1),
    .MemRead(mr1), .MemWrite(mw1), .IRWrite(irw1),
    .MemtoReg(m2r1), .RegDst(rd1), .RegWrite(rw1),
    .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUOp(aop1),
    .PCSource(pcs1), .illegal_op(ill1), .state(st1)
  );

  multicycle_control #(.MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset3), .Op(op3),
    .PCWrite(pcw3), .PCWriteCond(pcwc3), .IorD(iord3),
    .MemRead(mr3), .MemWrite(mw3), .IRWrite(irw3),
    .MemtoReg(m2r3), .RegDst(rd3), .RegWrite(rw3),
    .ALUSrcA(sa3), .ALUSrcB(sb3), .ALUOp(aop3),
    .PCSource(pcs3), .illegal_op(ill3), .state(st3)
  );

  alu_control u_aluc (.ALUOp(aop1), .funct(funct), .ALUCnt(alu_cnt));

  assign ctl1 = {pcw1, pcwc1, iord1, mr1, mw1, irw1, m2r1, rd1, rw1,
                 sa1, sb1, aop1, pcs1, ill1};
  assign ctl3 = {pcw3, pcwc3, iord3, mr3, mw3, irw3, m2r3, rd3, rw3,
                 sa3, sb3, aop3, pcs3, ill3};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b000010 || op == 6'b001000;
  endfunction

  // Expected control word for one cycle spent in state st
  function automatic logic [16:0] exp_ctl(input int st, input bit last,
                                          input bit ill);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, aop, pcs;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa} = '0;
    {sb, aop, pcs} = '0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; irw = last; pcw = last; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      9:  begin pcw = 1; pcs = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, pcs,
            ill};
  endfunction

  // Runs one instruction from its first FETCH cycle; abort_at >= 0
  // asserts reset on that cycle of the instruction instead.
  task automatic run_instr(input int lat, input logic [5:0] op,
                           input int abort_at);
    int seq[$];
    int st;
    bit last, ill;
    logic [3:0] obs_st;
    logic [16:0] obs_ctl;
    for (int i = 0; i < lat; i++) seq.push_back(0);
    seq.push_back(1);
    case (op)
      6'b000000: begin seq.push_back(6); seq.push_back(7); end
      6'b100011: begin
        seq.push_back(2);
        for (int i = 0; i < lat; i++) seq.push_back(3);
        seq.push_back(4);
      end
      6'b101011: begin
        seq.push_back(2);
        for (int i = 0; i < lat; i++) seq.push_back(5);
      end
      6'b000100: seq.push_back(8);
      6'b000010: seq.push_back(9);
      6'b001000: begin seq.push_back(10); seq.push_back(11); end
      default: ;
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      st   = seq[i];
      last = (st == 0) && (i == lat - 1);
      ill  = (st == 1) && !legal(op);
      if (lat == 1) op1 = (st == 1) ? op : 6'($urandom);
      else          op3 = (st == 1) ? op : 6'($urandom);
      if (i == abort_at) begin
        reset3 = 1'b1;
        #1;
        check($sformatf("abort_ctl op=%b i=%0d", op, i), 32'(ctl3), 0);
        @(posedge clk);
        #1;
        check("abort_state", 32'(st3), 0);
        check("abort_count", 32'(dut3.u_wait.count), 0);
        reset3 = 1'b0;
        return;
      end
      #1;
      obs_st  = (lat == 1) ? st1 : st3;
      obs_ctl = (lat == 1) ? ctl1 : ctl3;
      check($sformatf("L%0d op=%b i=%0d state", lat, op, i),
            32'(obs_st), 32'(st));
      check($sformatf("L%0d op=%b i=%0d ctl", lat, op, i),
            32'(obs_ctl), 32'(exp_ctl(st, last, ill)));
      if (lat == 1 && st == 6)
        check("alu_cnt_add", 32'(alu_cnt), 32'b0010);
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000010, 6'b001000, 6'b111111};

  function automatic logic [5:0] pick_op();
    if ($urandom_range(0, 4) == 0) return 6'($urandom);
    return ops[$urandom_range(0, 6)];
  endfunction

  initial begin
    reset1 = 1'b1;
    reset3 = 1'b1;
    op1    = 6'($urandom);
    op3    = 6'($urandom);
    funct  = 6'b100000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl1", 32'(ctl1), 0);
    check("reset_ctl3", 32'(ctl3), 0);
    check("reset_st1", 32'(st1), 0);
    check("reset_cnt3", 32'(dut3.u_wait.count), 0);
    reset1 = 1'b0;

    run_instr(1, 6'b000000, -1);
    run_instr(1, 6'b000100, -1);
    run_instr(1, 6'b000010, -1);
    run_instr(1, 6'b111111, -1);
    run_instr(1, 6'b100011, -1);
    run_instr(1, 6'b101011, -1);
    run_instr(1, 6'b001000, -1);
    for (int n = 0; n < 30; n++) run_instr(1, pick_op(), -1);

    reset1 = 1'b1;
    reset3 = 1'b0;
    run_instr(3, 6'b100011, -1);
    run_instr(3, 6'b101011, 6);
    run_instr(3, 6'b000000, -1);
    run_instr(3, 6'b111111, -1);
    run_instr(3, 6'b000100, -1);
    for (int n = 0; n < 20; n++) run_instr(3, pick_op(), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
